// File: rtl/pt_pkg.sv
// Shared constants and the translated-request entry layout for the pagetable
// read path.
package pt_pkg;

  localparam int PT_VIRT_W        = 58;
  localparam int PT_PHY_W         = 32;
  localparam int PT_LAT_DEFAULT   = 2;
  localparam int PT_TAG_W_DEFAULT = 14;

  // One queued translated read: physical line address plus its request tag.
  typedef struct packed {
    logic [PT_PHY_W-1:0]         phy_addr;
    logic [PT_TAG_W_DEFAULT-1:0] tag;
  } pt_rd_entry_t;

endpackage

// File: rtl/pt_rd_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra MSB so
// full and empty are told apart by the wrap bit.
module pt_rd_fifo #(
  parameter int W     = 46,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         wr_fire;
  logic         rd_fire;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a full FIFO still takes a write.
  assign rd_fire = rd_en_i & ~empty_o;
  assign wr_fire = wr_en_i & (~full_o | rd_fire);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Head is forced to zero while empty so stale storage never shows.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pt_rd_req_queue.sv
// Issues tagged virtual reads to the pagetable translator, realigns the
// fixed-latency physical address with its tag and queues the result for TX.
module pt_rd_req_queue
  import pt_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = PT_TAG_W_DEFAULT,
  parameter int PT_LAT = PT_LAT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PT_VIRT_W-1:0]   req_virt_addr,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             pt_status,
  output logic [PT_VIRT_W-1:0]   pt_virt_rd_addr,
  output logic                   pt_re_rd,
  input  logic [PT_PHY_W-1:0]    pt_phy_rd_addr,
  input  logic                   pt_phy_rd_addr_valid,
  output logic [PT_PHY_W-1:0]    tx_rd_addr,
  output logic [TAG_W-1:0]       tx_rd_tag,
  output logic                   tx_rd_valid,
  input  logic                   tx_rd_ready,
  output logic [$clog2(DEPTH):0] credits_used,
  output logic                   err
);

  // Handshakes: a transfer happens in a cycle where valid & ready are both
  // high at the clock edge; ready never depends on valid, and tx_rd_valid
  // stays high with a stable head until it is taken.

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PT_PHY_W + TAG_W;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CRED_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic                 ready_en_q;
  logic [CW-1:0]        credits_q, credits_d;
  logic                 re_q;
  logic [PT_VIRT_W-1:0] virt_q;
  logic [TAG_W-1:0]     tag_q;
  logic [PT_LAT-1:0]    dl_vld_q, dl_vld_d;
  logic [TAG_W-1:0]     dl_tag_q [PT_LAT];
  logic                 err_q, err_d;

  logic                 accept;
  logic                 pop;
  logic                 ret_exp;
  logic                 push_req;
  logic                 ret_mismatch;
  logic                 overflow;
  logic                 acct_err;
  logic                 fifo_wr;
  logic [EW-1:0]        fifo_rd;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 unused_status;

  assign unused_status = pt_status[1];

  // Gated for the first cycle out of reset, until status has been seen.
  assign req_ready = ready_en_q & pt_status[0] & (credits_q < DEPTH_C);
  assign accept    = req_valid & req_ready;
  assign pop       = tx_rd_valid & tx_rd_ready;

  assign ret_exp      = dl_vld_q[PT_LAT-1];
  assign ret_mismatch = ret_exp ^ pt_phy_rd_addr_valid;
  assign push_req     = ret_exp & pt_phy_rd_addr_valid;
  assign overflow     = push_req & fifo_full & ~pop;
  assign fifo_wr      = push_req & ~overflow;
  // Every queued entry holds a credit; more entries than credits is corruption.
  assign acct_err     = (fifo_count > credits_q);

  always_comb begin
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q + CRED_ONE;
      2'b01:   credits_d = credits_q - CRED_ONE;
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    dl_vld_d    = dl_vld_q;
    dl_vld_d[0] = re_q;
    for (int k = 1; k < PT_LAT; k++) begin
      dl_vld_d[k] = dl_vld_q[k-1];
    end
  end

  assign err_d = err_q | ret_mismatch | overflow | acct_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      credits_q  <= '0;
      re_q       <= 1'b0;
      virt_q     <= '0;
      tag_q      <= '0;
      dl_vld_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      credits_q  <= credits_d;
      re_q       <= accept;
      if (accept) begin
        virt_q <= req_virt_addr;
        tag_q  <= req_tag;
      end
      dl_vld_q   <= dl_vld_d;
      err_q      <= err_d;
    end
  end

  // Tags ride alongside the valid bits; only the valids need clearing.
  always_ff @(posedge clk) begin
    dl_tag_q[0] <= tag_q;
    for (int k = 1; k < PT_LAT; k++) begin
      dl_tag_q[k] <= dl_tag_q[k-1];
    end
  end

  pt_rd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({pt_phy_rd_addr, dl_tag_q[PT_LAT-1]}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign pt_virt_rd_addr = virt_q;
  assign pt_re_rd        = re_q;
  assign tx_rd_valid     = ~fifo_empty;
  assign {tx_rd_addr, tx_rd_tag} = fifo_rd;
  assign credits_used    = credits_q;
  assign err             = err_q;

endmodule

// File: tb/tb_pt_rd_req_queue.sv
// Self-checking bench for pt_rd_req_queue: directed scenarios plus random
// traffic, scored against a queue-based model of the request path.
module tb_pt_rd_req_queue;
  import pt_pkg::*;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = PT_TAG_W_DEFAULT;
  localparam int PT_LAT = PT_LAT_DEFAULT;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int EW     = PT_PHY_W + TAG_W;

  logic                 clk;
  logic                 rst;
  logic [PT_VIRT_W-1:0] req_virt_addr;
  logic [TAG_W-1:0]     req_tag;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           pt_status;
  logic [PT_VIRT_W-1:0] pt_virt_rd_addr;
  logic                 pt_re_rd;
  logic [PT_PHY_W-1:0]  pt_phy_rd_addr;
  logic                 pt_phy_rd_addr_valid;
  logic [PT_PHY_W-1:0]  tx_rd_addr;
  logic [TAG_W-1:0]     tx_rd_tag;
  logic                 tx_rd_valid;
  logic                 tx_rd_ready;
  logic [CW-1:0]        credits_used;
  logic                 err;

  pt_rd_req_queue #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .PT_LAT (PT_LAT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_virt_addr        (req_virt_addr),
    .req_tag              (req_tag),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .pt_status            (pt_status),
    .pt_virt_rd_addr      (pt_virt_rd_addr),
    .pt_re_rd             (pt_re_rd),
    .pt_phy_rd_addr       (pt_phy_rd_addr),
    .pt_phy_rd_addr_valid (pt_phy_rd_addr_valid),
    .tx_rd_addr           (tx_rd_addr),
    .tx_rd_tag            (tx_rd_tag),
    .tx_rd_valid          (tx_rd_valid),
    .tx_rd_ready          (tx_rd_ready),
    .credits_used         (credits_used),
    .err                  (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  typedef struct { int due; logic [TAG_W-1:0]    tag; } due_t;
  typedef struct { int due; logic [PT_PHY_W-1:0] phy; } trn_t;

  due_t                 due_q[$];   // what the model expects back, by cycle
  trn_t                 trn_q[$];   // what the translator will actually return
  logic [EW-1:0]        exp_q[$];   // expected FIFO contents, head first
  int                   m_credits;
  bit                   m_err;
  bit                   m_ready_en;
  bit                   m_re;
  logic [PT_VIRT_W-1:0] m_virt;
  int                   cyc;
  int                   acc_cnt;
  int                   checks;
  int                   errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic logic [PT_VIRT_W-1:0] rand_virt();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[PT_VIRT_W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_return(input bit spur, output bit ret_v, output logic [PT_PHY_W-1:0] ret_a);
    ret_v = 1'b0;
    ret_a = $urandom;
    if (trn_q.size() > 0 && trn_q[0].due == cyc) begin
      ret_v = 1'b1;
      ret_a = trn_q[0].phy;
      trn_q.delete(0);
    end else if (spur) begin
      ret_v = 1'b1;
    end
    pt_phy_rd_addr       = ret_a;
    pt_phy_rd_addr_valid = ret_v;
  endtask

  task automatic step(input bit rv, input logic [PT_VIRT_W-1:0] va, input logic [TAG_W-1:0] tg,
                      input logic [PT_PHY_W-1:0] ph, input bit txr, input bit st, input bit spur);
    bit                  ret_v, exp_rdy, acc, pop, match;
    logic [PT_PHY_W-1:0] ret_a;
    logic [TAG_W-1:0]    due_tag;
    pt_rd_entry_t        h;
    req_valid     = rv;
    req_virt_addr = va;
    req_tag       = tg;
    tx_rd_ready   = txr;
    pt_status     = {1'b0, st};
    drive_return(spur, ret_v, ret_a);
    #2;
    exp_rdy = m_ready_en && st && (m_credits < DEPTH);
    chk("req_ready", req_ready, exp_rdy);
    chk("pt_re_rd", pt_re_rd, m_re);
    chk("pt_virt_rd_addr", pt_virt_rd_addr, m_virt);
    chk("credits_used", credits_used, m_credits);
    chk("err", err, m_err);
    chk("tx_rd_valid", tx_rd_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("tx_rd_addr", tx_rd_addr, h.phy_addr);
      chk("tx_rd_tag", tx_rd_tag, h.tag);
    end
    acc   = rv && exp_rdy;
    pop   = (exp_q.size() > 0) && txr;
    match = (due_q.size() > 0) && (due_q[0].due == cyc);
    due_tag = '0;
    if (match) begin
      due_tag = due_q[0].tag;
      due_q.delete(0);
    end
    if (match != ret_v) m_err = 1'b1;
    if (pop) begin
      exp_q.delete(0);
      m_credits--;
    end
    if (match && ret_v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({ret_a, due_tag});
      else m_err = 1'b1;
    end
    if (acc) begin
      m_credits++;
      acc_cnt++;
      due_q.push_back('{due: cyc + 1 + PT_LAT, tag: tg});
      trn_q.push_back('{due: cyc + 1 + PT_LAT, phy: ph});
      m_virt = va;
    end
    m_re       = acc;
    m_ready_en = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit txr, input bit st);
    for (int i = 0; i < n; i++) step(1'b0, rand_virt(), TAG_W'($urandom), $urandom, txr, st, 1'b0);
  endtask

  // Translator returns still arrive during reset; the model forgets its own
  // outstanding list so any that land afterwards are unexpected.
  task automatic do_reset(input int n);
    bit                  rv_d;
    logic [PT_PHY_W-1:0] a_d;
    rst         = 1'b1;
    req_valid   = 1'b0;
    tx_rd_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_return(1'b0, rv_d, a_d);
      @(posedge clk);
      #1;
      cyc++;
    end
    rst        = 1'b0;
    due_q.delete();
    exp_q.delete();
    m_credits  = 0;
    m_err      = 1'b0;
    m_ready_en = 1'b0;
    m_re       = 1'b0;
    m_virt     = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    checks = 0; errors = 0; cyc = 0; acc_cnt = 0;
    req_valid = 1'b0; req_virt_addr = '0; req_tag = '0; tx_rd_ready = 1'b0;
    pt_status = 2'b00; pt_phy_rd_addr = '0; pt_phy_rd_addr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);
    chk("reset_tx_rd_addr", tx_rd_addr, 0);
    chk("reset_tx_rd_tag", tx_rd_tag, 0);

    // Single request.
    idle(2, 1'b1, 1'b1);
    step(1'b1, 58'h1000, 14'd5, 32'h0004_2000, 1'b1, 1'b1, 1'b0);
    idle(8, 1'b1, 1'b1);
    chk("single_credits_back", credits_used, 0);

    // Back-pressure fill, then drain in order.
    base = acc_cnt;
    for (int i = 0; i < 20; i++) step(1'b1, rand_virt(), TAG_W'(i), $urandom, 1'b0, 1'b1, 1'b0);
    chk("fill_accepts", acc_cnt - base, DEPTH);
    chk("fill_credits", credits_used, DEPTH);
    idle(24, 1'b1, 1'b1);

    // Streaming with the sink always ready.
    base = acc_cnt;
    for (int i = 0; i < 100; i++) step(1'b1, rand_virt(), TAG_W'(i), $urandom, 1'b1, 1'b1, 1'b0);
    idle(10, 1'b1, 1'b1);
    chk("stream_accepts", acc_cnt - base, 100);
    chk("stream_err", err, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), rand_virt(), TAG_W'($urandom), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, 1'b0);
    idle(12, 1'b1, 1'b1);

    // Status drops after three requests are issued.
    base = acc_cnt;
    for (int i = 0; i < 3; i++) step(1'b1, rand_virt(), TAG_W'(100 + i), $urandom, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, rand_virt(), TAG_W'(200 + i), $urandom, 1'b1, 1'b0, 1'b0);
    idle(8, 1'b1, 1'b0);
    chk("status_drop_accepts", acc_cnt - base, 3);
    chk("status_drop_drained", tx_rd_valid, 0);

    // Spurious translator return.
    idle(2, 1'b1, 1'b1);
    step(1'b0, rand_virt(), '0, $urandom, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    chk("spurious_err", err, 1);
    chk("spurious_credits", credits_used, 0);

    // Reset with five queued and two in flight; late returns flag err.
    for (int i = 0; i < 5; i++) step(1'b1, rand_virt(), TAG_W'(300 + i), $urandom, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0, 1'b1);
    chk("pre_reset_credits", credits_used, 5);
    for (int i = 0; i < 2; i++) step(1'b1, rand_virt(), TAG_W'(400 + i), $urandom, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    chk("post_reset_credits", credits_used, 0);
    chk("post_reset_tx_valid", tx_rd_valid, 0);
    chk("post_reset_err", err, 0);
    idle(6, 1'b1, 1'b1);
    chk("late_return_err", err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
